disaster_sensor_scanner: RTL and testbench

- Sequential acquisition front-end that produces the four sensor readings (rain, seismic, wind, sea) consumed by the disaster classifier.
- Scans one shared external ADC over a four-phase req/ack handshake, one channel at a time.
- Scales and saturates each sample into the classifier's input ranges.
- Publishes all four values together as a coherent frame, with a one-cycle valid strobe, at a fixed scan interval.

---
 rtl/disaster_sensor_scanner.sv | 201 ++++++++++++++++++++
 tb/tb_disaster_sensor_scanner.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disaster_sensor_scanner.sv
// Four-channel acquisition front-end: scans one shared ADC over a req/ack handshake,
// scales/saturates each sample and publishes rain/seismic/wind/sea as one coherent frame.
module disaster_sensor_scanner #(
  parameter int unsigned ADC_W      = 10,
  parameter int unsigned SEIS_SHIFT = 5,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clr_err,
  output logic             adc_req,
  output logic [1:0]       adc_ch,
  input  logic             adc_ack,
  input  logic [ADC_W-1:0] adc_data,
  output logic [6:0]       rain,
  output logic [4:0]       seismic,
  output logic [6:0]       wind,
  output logic [6:0]       sea,
  output logic             frame_valid,
  output logic [7:0]       frame_count,
  output logic             timeout_err
);

  localparam int unsigned      TMR_W   = $clog2(SCAN_DIV);
  localparam int unsigned      WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(SCAN_DIV - 1);
  localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_RELEASE = 2'd2,
    S_PUBLISH = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             started_q, started_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             req_q, req_d;
  logic [1:0]       ch_q, ch_d;
  logic [6:0]       sh_rain_q, sh_rain_d, sh_wind_q, sh_wind_d, sh_sea_q, sh_sea_d;
  logic [4:0]       sh_seis_q, sh_seis_d;
  logic [6:0]       rain_q, rain_d, wind_q, wind_d, sea_q, sea_d;
  logic [4:0]       seis_q, seis_d;
  logic             fv_q, fv_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [ADC_W-1:0] seis_shift_c;
  logic [6:0]       lin_scaled_c;
  logic [4:0]       seis_scaled_c;
  logic             expired_c;
  logic             timeout_c;

  // Sample scaling into classifier ranges
  always_comb begin
    seis_shift_c  = adc_data >> SEIS_SHIFT;
    lin_scaled_c  = (adc_data > ADC_W'(127)) ? 7'd127 : adc_data[6:0];
    seis_scaled_c = (seis_shift_c > ADC_W'(31)) ? 5'd31 : seis_shift_c[4:0];
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    timer_d   = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_W'(1);
    started_d = started_q;
    wdog_d    = wdog_q;
    req_d     = 1'b0;
    ch_d      = ch_q;
    sh_rain_d = sh_rain_q;
    sh_seis_d = sh_seis_q;
    sh_wind_d = sh_wind_q;
    sh_sea_d  = sh_sea_q;
    rain_d    = rain_q;
    seis_d    = seis_q;
    wind_d    = wind_q;
    sea_d     = sea_q;
    fv_d      = 1'b0;
    cnt_d     = cnt_q;
    timeout_c = 1'b0;
    // First frame after reset may start at once
    expired_c = !started_q || (timer_q == TMR_MAX);

    case (state_q)
      S_IDLE: begin
        if (enable && expired_c) begin
          state_d   = S_REQ;
          ch_d      = 2'd0;
          req_d     = 1'b1;
          timer_d   = '0;
          started_d = 1'b1;
          wdog_d    = '0;
        end
      end
      S_REQ: begin
        req_d = 1'b1;
        if (adc_ack) begin
          case (ch_q)
            2'd0:    sh_rain_d = lin_scaled_c;
            2'd1:    sh_seis_d = seis_scaled_c;
            2'd2:    sh_wind_d = lin_scaled_c;
            default: sh_sea_d  = lin_scaled_c;
          endcase
          state_d = S_RELEASE;
          req_d   = 1'b0;
          wdog_d  = '0;
        end else if (wdog_q == WD_MAX) begin
          // Dead channel reads full scale so the classifier errs toward alarm
          case (ch_q)
            2'd0:    sh_rain_d = 7'd127;
            2'd1:    sh_seis_d = 5'd31;
            2'd2:    sh_wind_d = 7'd127;
            default: sh_sea_d  = 7'd127;
          endcase
          timeout_c = 1'b1;
          state_d   = S_RELEASE;
          req_d     = 1'b0;
          wdog_d    = '0;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      S_RELEASE: begin
        if (!adc_ack) begin
          if (ch_q == 2'd3) begin
            state_d = S_PUBLISH;
            rain_d  = sh_rain_q;
            seis_d  = sh_seis_q;
            wind_d  = sh_wind_q;
            sea_d   = sh_sea_q;
            fv_d    = 1'b1;
            cnt_d   = cnt_q + 8'd1;
          end else begin
            state_d = S_REQ;
            ch_d    = ch_q + 2'd1;
            req_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    err_d = timeout_c ? 1'b1 : (clr_err ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      started_q <= 1'b0;
      wdog_q    <= '0;
      req_q     <= 1'b0;
      ch_q      <= 2'd0;
      sh_rain_q <= '0;
      sh_seis_q <= '0;
      sh_wind_q <= '0;
      sh_sea_q  <= '0;
      rain_q    <= '0;
      seis_q    <= '0;
      wind_q    <= '0;
      sea_q     <= '0;
      fv_q      <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      started_q <= started_d;
      wdog_q    <= wdog_d;
      req_q     <= req_d;
      ch_q      <= ch_d;
      sh_rain_q <= sh_rain_d;
      sh_seis_q <= sh_seis_d;
      sh_wind_q <= sh_wind_d;
      sh_sea_q  <= sh_sea_d;
      rain_q    <= rain_d;
      seis_q    <= seis_d;
      wind_q    <= wind_d;
      sea_q     <= sea_d;
      fv_q      <= fv_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign adc_req     = req_q;
  assign adc_ch      = ch_q;
  assign rain        = rain_q;
  assign seismic     = seis_q;
  assign wind        = wind_q;
  assign sea         = sea_q;
  assign frame_valid = fv_q;
  assign frame_count = cnt_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_disaster_sensor_scanner.sv
// Bench for disaster_sensor_scanner: behavioural ADC responder plus a frame-level
// reference model of the scaling, timeout and frame-count rules.
module tb_disaster_sensor_scanner;

  localparam int ADC_W      = 10;
  localparam int SEIS_SHIFT = 5;
  localparam int SCAN_DIV   = 128;
  localparam int TIMEOUT    = 255;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic             clr_err = 1'b0;
  logic             adc_req;
  logic [1:0]       adc_ch;
  logic             adc_ack = 1'b0;
  logic [ADC_W-1:0] adc_data = '0;
  logic [6:0]       rain, wind, sea;
  logic [4:0]       seismic;
  logic             frame_valid;
  logic [7:0]       frame_count;
  logic             timeout_err;

  disaster_sensor_scanner #(
    .ADC_W(ADC_W), .SEIS_SHIFT(SEIS_SHIFT), .SCAN_DIV(SCAN_DIV), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .clr_err(clr_err),
    .adc_req(adc_req), .adc_ch(adc_ch), .adc_ack(adc_ack), .adc_data(adc_data),
    .rain(rain), .seismic(seismic), .wind(wind), .sea(sea),
    .frame_valid(frame_valid), .frame_count(frame_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int exp_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ADC responder: acks ack_delay cycles after req, holds ack hold_extra extra cycles after req falls
  int ack_delay = 0;
  int hold_extra = 0;
  int never_ch = -1;
  int vals[4];
  int wait_cnt = 0;
  int hold_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      adc_ack = 1'b0;
      wait_cnt = 0;
    end else if (adc_req) begin
      if (!adc_ack && int'(adc_ch) != never_ch) begin
        if (wait_cnt >= ack_delay) begin
          adc_ack  = 1'b1;
          adc_data = ADC_W'(vals[adc_ch]);
          hold_cnt = hold_extra;
        end else begin
          wait_cnt++;
        end
      end
    end else begin
      wait_cnt = 0;
      if (adc_ack) begin
        if (hold_cnt > 0) hold_cnt--;
        else adc_ack = 1'b0;
      end
    end
  end

  // Channel-order log and output-stability watch
  logic [1:0]  ch_log[$];
  logic        prev_req = 1'b0;
  logic [33:0] last_out = '0;
  int          stable_viol = 0;

  always @(negedge clk) begin
    if (adc_req && !prev_req) ch_log.push_back(adc_ch);
    prev_req = adc_req;
    if (!rst && !frame_valid && {rain, seismic, wind, sea, frame_count} !== last_out)
      stable_viol++;
    last_out = {rain, seismic, wind, sea, frame_count};
  end

  function automatic logic [7:0] ref_val(int c, int raw, bit timed_out);
    int v;
    if (c == 1) begin
      v = raw / (2 ** SEIS_SHIFT);
      if (v > 31) v = 31;
      if (timed_out) v = 31;
    end else begin
      v = (raw > 127) ? 127 : raw;
      if (timed_out) v = 127;
    end
    return 8'(v);
  endfunction

  function automatic logic [7:0] out_field(int c);
    case (c)
      0:       return 8'(rain);
      1:       return 8'(seismic);
      2:       return 8'(wind);
      default: return 8'(sea);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fv(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (frame_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_req_ch(input int ch, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (adc_req && int'(adc_ch) == ch) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst = 1'b1;
    repeat (3) step();
    n_total++;
    if ({adc_req, adc_ch, rain, seismic, wind, sea, frame_valid, frame_count, timeout_err} !== '0)
      $display("FAIL reset_outputs got %h exp 0",
               {adc_req, adc_ch, rain, seismic, wind, sea, frame_valid, frame_count, timeout_err});
    else n_pass++;
    vals = '{25, 400, 45, 10};
    rst = 1'b0;
    enable = 1'b1;
    wait_req_ch(1, 200, ok);
    n_total++;
    if (!ok) $display("FAIL reset_reach_ch1 got no request exp request within 200 cycles");
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (adc_req !== 1'b0) $display("FAIL reset_async_req got %b exp 0", adc_req);
    else n_pass++;
    n_total++;
    if ({rain, seismic, wind, sea, frame_count, timeout_err, frame_valid} !== '0)
      $display("FAIL reset_mid_outputs got %h exp 0",
               {rain, seismic, wind, sea, frame_count, timeout_err, frame_valid});
    else n_pass++;
    step();
    rst = 1'b0;
    exp_cnt = 0;
    ch_log.delete();
    wait_fv(300, ok);
    exp_cnt++;
    n_total++;
    if (!ok || frame_count !== 8'(exp_cnt))
      $display("FAIL reset_restart_frame got ok=%0d count=%0d exp ok=1 count=%0d", ok, frame_count, exp_cnt);
    else n_pass++;
    ch_log.delete();
  endtask

  task automatic test_nominal();
    bit ok;
    vals = '{25, 400, 45, 10};
    wait_fv(400, ok);
    exp_cnt++;
    n_total++;
    if (!ok) $display("FAIL nominal_frame got no frame_valid exp frame_valid");
    else n_pass++;
    for (int c = 0; c < 4; c++) begin
      n_total++;
      if (out_field(c) !== ref_val(c, vals[c], 1'b0))
        $display("FAIL nominal_ch%0d got %0d exp %0d", c, out_field(c), ref_val(c, vals[c], 1'b0));
      else n_pass++;
    end
    n_total++;
    if (frame_count !== 8'(exp_cnt)) $display("FAIL nominal_count got %0d exp %0d", frame_count, exp_cnt);
    else n_pass++;
    n_total++;
    if (ch_log.size() != 4 || ch_log[0] !== 2'd0 || ch_log[1] !== 2'd1 ||
        ch_log[2] !== 2'd2 || ch_log[3] !== 2'd3)
      $display("FAIL nominal_order got %p exp '{0,1,2,3}", ch_log);
    else n_pass++;
    step();
    n_total++;
    if (frame_valid !== 1'b0) $display("FAIL nominal_pulse_width got %b exp 0", frame_valid);
    else n_pass++;
    ch_log.delete();
  endtask

  task automatic test_saturation();
    bit ok;
    vals = '{500, 1023, 128, 127};
    wait_fv(400, ok);
    exp_cnt++;
    n_total++;
    if (!ok) $display("FAIL sat_frame got no frame_valid exp frame_valid");
    else n_pass++;
    for (int c = 0; c < 4; c++) begin
      n_total++;
      if (out_field(c) !== ref_val(c, vals[c], 1'b0))
        $display("FAIL sat_ch%0d got %0d exp %0d", c, out_field(c), ref_val(c, vals[c], 1'b0));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int f = 0; f < 20; f++) begin
      for (int c = 0; c < 4; c++)
        vals[c] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 160)) : int'($urandom_range(0, 1023));
      ack_delay = int'($urandom_range(0, 3));
      wait_fv(400, ok);
      exp_cnt++;
      n_total++;
      if (!ok || frame_count !== 8'(exp_cnt))
        $display("FAIL rand_frame%0d got ok=%0d count=%0d exp ok=1 count=%0d", f, ok, frame_count, exp_cnt);
      else n_pass++;
      for (int c = 0; c < 4; c++) begin
        n_total++;
        if (out_field(c) !== ref_val(c, vals[c], 1'b0))
          $display("FAIL rand_f%0d_ch%0d raw %0d got %0d exp %0d", f, c, vals[c], out_field(c),
                   ref_val(c, vals[c], 1'b0));
        else n_pass++;
      end
    end
    ack_delay = 0;
    n_total++;
    if (stable_viol != 0) $display("FAIL output_stability got %0d changes exp 0", stable_viol);
    else n_pass++;
  endtask

  task automatic test_interval();
    bit ok;
    int t0;
    wait_fv(400, ok);
    exp_cnt++;
    t0 = cyc;
    for (int k = 0; k < 2; k++) begin
      wait_fv(400, ok);
      exp_cnt++;
      n_total++;
      if (!ok || cyc - t0 != SCAN_DIV)
        $display("FAIL interval%0d got %0d cycles exp %0d", k, cyc - t0, SCAN_DIV);
      else n_pass++;
      t0 = cyc;
    end
  endtask

  task automatic test_ack_hold();
    bit ok;
    int viol = 0;
    int high = 0;
    logic [1:0] ch0;
    hold_extra = 5;
    vals = '{7, 64, 99, 120};
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (adc_ack) begin
        ok = 1'b1;
        break;
      end
    end
    ch0 = adc_ch;
    for (int i = 0; i < 20 && adc_ack; i++) begin
      if (adc_req || adc_ch !== ch0) viol++;
      high++;
      step();
    end
    n_total++;
    if (!ok || viol != 0 || high < 5)
      $display("FAIL ack_hold got ok=%0d viol=%0d high=%0d exp ok=1 viol=0 high>=5", ok, viol, high);
    else n_pass++;
    wait_fv(600, ok);
    exp_cnt++;
    hold_extra = 0;
    for (int c = 0; c < 4; c++) begin
      n_total++;
      if (!ok || out_field(c) !== ref_val(c, vals[c], 1'b0))
        $display("FAIL ack_hold_ch%0d got %0d exp %0d", c, out_field(c), ref_val(c, vals[c], 1'b0));
      else n_pass++;
    end
  endtask

  task automatic test_slow_adc();
    bit ok;
    int n = 0;
    ack_delay = 60;
    wait_fv(2000, ok);
    exp_cnt++;
    for (int i = 0; i < 10; i++) begin
      step();
      n++;
      if (adc_req) break;
    end
    n_total++;
    if (!ok || n != 2) $display("FAIL slow_restart got %0d cycles exp 2", n);
    else n_pass++;
    ack_delay = 0;
    wait_fv(2000, ok);
    exp_cnt++;
    n_total++;
    if (!ok || frame_count !== 8'(exp_cnt)) $display("FAIL slow_count got %0d exp %0d", frame_count, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_timeout();
    bit ok;
    int req_len = 0;
    bit pr;
    vals = '{30, 300, 50, 60};
    never_ch = 2;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (adc_req && adc_ch == 2'd2) req_len++;
      if (frame_valid) begin
        ok = 1'b1;
        break;
      end
    end
    exp_cnt++;
    n_total++;
    if (!ok || req_len != TIMEOUT) $display("FAIL timeout_req_len got %0d exp %0d", req_len, TIMEOUT);
    else n_pass++;
    for (int c = 0; c < 4; c++) begin
      n_total++;
      if (out_field(c) !== ref_val(c, vals[c], c == 2))
        $display("FAIL timeout_ch%0d got %0d exp %0d", c, out_field(c), ref_val(c, vals[c], c == 2));
      else n_pass++;
    end
    n_total++;
    if (timeout_err !== 1'b1) $display("FAIL timeout_err_set got %b exp 1", timeout_err);
    else n_pass++;
    never_ch = -1;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    n_total++;
    if (timeout_err !== 1'b0) $display("FAIL timeout_err_clr got %b exp 0", timeout_err);
    else n_pass++;
    never_ch = 2;
    clr_err = 1'b1;
    ok = 1'b0;
    pr = adc_req;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (pr && !adc_req && adc_ch == 2'd2) begin
        ok = 1'b1;
        break;
      end
      pr = adc_req;
    end
    n_total++;
    if (!ok || timeout_err !== 1'b1) $display("FAIL timeout_set_wins got ok=%0d err=%b exp ok=1 err=1", ok, timeout_err);
    else n_pass++;
    step();
    n_total++;
    if (timeout_err !== 1'b0) $display("FAIL timeout_clr_after got %b exp 0", timeout_err);
    else n_pass++;
    clr_err = 1'b0;
    never_ch = -1;
    wait_fv(400, ok);
    exp_cnt++;
    n_total++;
    if (!ok || wind !== 7'd127 || timeout_err !== 1'b0)
      $display("FAIL timeout_second_frame got wind=%0d err=%b exp wind=127 err=0", wind, timeout_err);
    else n_pass++;
  endtask

  task automatic test_enable_drop();
    bit ok;
    int reqs = 0;
    vals = '{1, 2, 3, 4};
    wait_req_ch(1, 400, ok);
    enable = 1'b0;
    wait_fv(400, ok);
    exp_cnt++;
    n_total++;
    if (!ok || frame_count !== 8'(exp_cnt) || rain !== 7'd1)
      $display("FAIL enable_drop_publish got count=%0d rain=%0d exp count=%0d rain=1", frame_count, rain, exp_cnt);
    else n_pass++;
    repeat (3 * SCAN_DIV) begin
      step();
      if (adc_req) reqs++;
    end
    n_total++;
    if (reqs != 0) $display("FAIL enable_drop_idle got %0d request cycles exp 0", reqs);
    else n_pass++;
  endtask

  task automatic test_wrap();
    bit ok;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    exp_cnt = 0;
    enable = 1'b1;
    vals = '{10, 20, 30, 40};
    for (int f = 0; f < 256; f++) begin
      wait_fv(400, ok);
      exp_cnt++;
      n_total++;
      if (!ok || frame_count !== 8'(exp_cnt))
        $display("FAIL wrap_frame%0d got ok=%0d count=%0d exp %0d", f, ok, frame_count, 8'(exp_cnt));
      else n_pass++;
    end
    n_total++;
    if (frame_count !== 8'd0) $display("FAIL wrap_zero got %0d exp 0", frame_count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_saturation();
    test_random();
    test_interval();
    test_ack_hold();
    test_slow_adc();
    test_timeout();
    test_enable_drop();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
